// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory controller:
// FSM state encoding, timeout default and wait-counter width.
package mem_stage_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;
  localparam state_t ST_ERROR  = 2'd3;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for memory accesses: clear, enable, saturating count,
// terminal flag raised when the count reaches TIMEOUT-1.
module mem_timeout_ctr
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data memory controller: issues a registered request per load/store,
// stalls the upstream pipeline until ack or timeout, flushes MEM/WB meanwhile.
//
// state  | meaning
// IDLE   | no access in flight; a pending load/store launches a request
// ACCESS | request outstanding, waiting for dmem_ack or timeout
// DONE   | access finished, pipeline advances, MEM/WB takes the result
// ERROR  | access timed out, one-cycle bus_error, bubble into MEM/WB
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] mem_data_out,
  output logic        stall_out,
  output logic        memwb_flush,
  output logic        bus_error
);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        ctr_clr, ctr_en, ctr_tc;
  logic        access;
  state_t      state_eff;

  assign access = mem_read_in | mem_write_in;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .tc_o  (ctr_tc)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          // a simultaneous read+write is handled as a store
          addr_d  = addr_in;
          wdata_d = wdata_in;
          we_d    = mem_write_in;
          req_d   = 1'b1;
          ctr_clr = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ctr_en = 1'b1;
        if (dmem_ack) begin
          if (!we_q) begin
            data_d = dmem_rdata;
          end
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (ctr_tc) begin
          req_d   = 1'b0;
          state_d = ST_ERROR;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // while reset is asserted the outputs decode as IDLE so no stale error leaks out
  assign state_eff = rst_n ? state_q : ST_IDLE;

  assign stall_out   = ((state_eff == ST_IDLE) && access) || (state_eff == ST_ACCESS);
  assign memwb_flush = ((state_eff == ST_IDLE) && access) || (state_eff == ST_ACCESS) ||
                       (state_eff == ST_ERROR);
  assign bus_error   = (state_eff == ST_ERROR);

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign mem_data_out = data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl with hand-computed expected values.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] mem_data_out;
  logic        stall_out;
  logic        memwb_flush;
  logic        bus_error;

  int vectors = 0;
  int miscompares = 0;

  mem_stage_ctrl #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .mem_data_out (mem_data_out),
    .stall_out    (stall_out),
    .memwb_flush  (memwb_flush),
    .bus_error    (bus_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one access from IDLE and run it to DONE/ERROR. ack_wait is the
  // ACCESS-cycle index (0-based) on which dmem_ack is given; -1 means never.
  // Returns with the DUT in DONE or ERROR, inputs still applied, ack low.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_wait,
                           input logic [31:0] rdata, output int stalls,
                           output int acc_cycles);
    int guard;
    mem_read_in  = rd;
    mem_write_in = wr;
    addr_in      = a;
    wdata_in     = wd;
    dmem_ack     = 1'b0;
    stalls       = 0;
    acc_cycles   = 0;
    guard        = 0;
    #1;
    while (stall_out === 1'b1 && guard < 300) begin
      stalls++;
      if (dmem_req === 1'b1) begin
        if (acc_cycles == ack_wait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        acc_cycles++;
      end
      step();
      dmem_ack = 1'b0;
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    addr_in = 32'h0; wdata_in = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    step(); step();
    vectors++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_we: got req=%b we=%b want 0 0", dmem_req, dmem_we);
    end
    vectors++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || mem_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h wdata=%h data=%h want all 0",
               dmem_addr, dmem_wdata, mem_data_out);
    end
    vectors++;
    if (bus_error !== 1'b0 || stall_out !== 1'b0 || memwb_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got err=%b stall=%b flush=%b want 0 0 0",
               bus_error, stall_out, memwb_flush);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (bus_error !== 1'b0 || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got err=%b stall=%b req=%b want 0 0 0",
               bus_error, stall_out, dmem_req);
    end
  endtask

  task automatic test_load();
    int s, a;
    mem_read_in = 1'b1; addr_in = 32'h100; #1;
    vectors++;
    if (stall_out !== 1'b1 || memwb_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL load_idle_stall: got stall=%b flush=%b want 1 1", stall_out, memwb_flush);
    end
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, s, a);
    vectors++;
    if (s != 2) begin
      miscompares++;
      $display("FAIL load_stall_cycles: got %0d want 2", s);
    end
    vectors++;
    if (mem_data_out !== 32'hDEADBEEF || memwb_flush !== 1'b0 || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL load_done: got data=%h flush=%b req=%b want deadbeef 0 0",
               mem_data_out, memwb_flush, dmem_req);
    end
    vectors++;
    if (dmem_addr !== 32'h100 || dmem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL load_addr_we: got addr=%h we=%b want 00000100 0", dmem_addr, dmem_we);
    end
    mem_read_in = 1'b0;
    step();
  endtask

  task automatic test_store();
    int s, a;
    do_access(1'b0, 1'b1, 32'h200, 32'h12345678, 3, 32'hCAFEF00D, s, a);
    vectors++;
    if (s != 5 || a != 4) begin
      miscompares++;
      $display("FAIL store_stall_cycles: got stall=%0d access=%0d want 5 4", s, a);
    end
    vectors++;
    if (dmem_we !== 1'b1 || dmem_addr !== 32'h200 || dmem_wdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL store_bus: got we=%b addr=%h wdata=%h want 1 00000200 12345678",
               dmem_we, dmem_addr, dmem_wdata);
    end
    vectors++;
    if (mem_data_out !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL store_data_kept: got %h want deadbeef", mem_data_out);
    end
    mem_write_in = 1'b0;
    step();
  endtask

  task automatic test_rw_both();
    int s, a;
    do_access(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 0, 32'h11111111, s, a);
    vectors++;
    if (dmem_we !== 1'b1 || mem_data_out !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rw_both_is_store: got we=%b data=%h want 1 deadbeef", dmem_we, mem_data_out);
    end
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int s, a;
    do_access(1'b1, 1'b0, 32'h400, 32'h0, -1, 32'h0, s, a);
    vectors++;
    if (a != 16 || s != 17) begin
      miscompares++;
      $display("FAIL timeout_cycles: got access=%0d stall=%0d want 16 17", a, s);
    end
    vectors++;
    if (bus_error !== 1'b1 || memwb_flush !== 1'b1 || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_error_state: got err=%b flush=%b stall=%b req=%b want 1 1 0 0",
               bus_error, memwb_flush, stall_out, dmem_req);
    end
    vectors++;
    if (mem_data_out !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL timeout_data_kept: got %h want deadbeef", mem_data_out);
    end
    mem_read_in = 1'b0;
    step();
    vectors++;
    if (bus_error !== 1'b0 || memwb_flush !== 1'b0 || stall_out !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse_width: got err=%b flush=%b stall=%b want 0 0 0",
               bus_error, memwb_flush, stall_out);
    end
  endtask

  task automatic test_ack_at_limit();
    int s, a;
    do_access(1'b1, 1'b0, 32'h500, 32'h0, 15, 32'h0BADF00D, s, a);
    vectors++;
    if (a != 16 || s != 17) begin
      miscompares++;
      $display("FAIL limit_cycles: got access=%0d stall=%0d want 16 17", a, s);
    end
    vectors++;
    if (bus_error !== 1'b0 || memwb_flush !== 1'b0 || mem_data_out !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL limit_ack_wins: got err=%b flush=%b data=%h want 0 0 0badf00d",
               bus_error, memwb_flush, mem_data_out);
    end
    mem_read_in = 1'b0;
    step();
    vectors++;
    if (bus_error !== 1'b0) begin
      miscompares++;
      $display("FAIL limit_no_error_after: got %b want 0", bus_error);
    end
  endtask

  task automatic test_ack_ignored();
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    step(); step();
    dmem_ack = 1'b0;
    vectors++;
    if (mem_data_out !== 32'h0BADF00D || dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack_ignored: got data=%h req=%b stall=%b want 0badf00d 0 0",
               mem_data_out, dmem_req, stall_out);
    end
  endtask

  task automatic test_reset_mid_access();
    mem_read_in = 1'b1; addr_in = 32'h600;
    step();
    step();
    vectors++;
    if (dmem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_in_access: got req=%b want 1", dmem_req);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_error !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_err_in_reset: got %b want 0", bus_error);
    end
    step();
    rst_n = 1'b1;
    mem_read_in = 1'b0;
    #1;
    vectors++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || mem_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_dropped: got req=%b stall=%b data=%h want 0 0 0",
               dmem_req, stall_out, mem_data_out);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    step();
    dmem_ack = 1'b0;
    step();
    vectors++;
    if (mem_data_out !== 32'h0 || dmem_req !== 1'b0 || bus_error !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_late_ack: got data=%h req=%b err=%b want 0 0 0",
               mem_data_out, dmem_req, bus_error);
    end
  endtask

  task automatic test_back_to_back();
    int s, a;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h10101010, s, a);
    mem_read_in = 1'b1; addr_in = 32'h14;
    #1;
    vectors++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || mem_data_out !== 32'h10101010) begin
      miscompares++;
      $display("FAIL b2b_done: got req=%b stall=%b data=%h want 0 0 10101010",
               dmem_req, stall_out, mem_data_out);
    end
    step();
    vectors++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle: got req=%b stall=%b want 0 1", dmem_req, stall_out);
    end
    do_access(1'b1, 1'b0, 32'h14, 32'h0, 0, 32'h14141414, s, a);
    vectors++;
    if (s != 2 || dmem_addr !== 32'h14 || mem_data_out !== 32'h14141414) begin
      miscompares++;
      $display("FAIL b2b_second: got stall=%0d addr=%h data=%h want 2 00000014 14141414",
               s, dmem_addr, mem_data_out);
    end
    mem_read_in = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_rw_both();
    test_timeout();
    test_ack_at_limit();
    test_ack_ignored();
    test_reset_mid_access();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
